hd_timing_gen: RTL
==================

// Module: hd_timing_gen
// PURPOSE
//   Generates 1280x720 HD raster timing in the single system clock domain: pixel strobe, hsync,
//   vsync, data-enable and pixel coordinates. Sits alongside the PAL-to-HD upsampler: drives its
//   HD hsync/vsync/clk inputs and consumes its one-cycle frame-end pulse. Optionally re-phases the
//   vertical counter so HD frames stay locked to the PAL source.
// PARAMETERS
//   CLK_DIV    2     system clocks per HD pixel (>=2)
//   H_ACTIVE   1280  active pixels per line
//   H_FP       110   horizontal front porch, pixels
//   H_SYNC     40    hsync width, pixels
//   H_BP       220   horizontal back porch, pixels
//   V_ACTIVE   720   active lines per frame
//   V_FP       5     vertical front porch, lines
//   V_SYNC     5     vsync width, lines
//   V_BP       20    vertical back porch, lines
//   LOCK_LINE  0     line loaded into v counter on re-phase
//   LOCK_TOL   2     |v - LOCK_LINE| (lines) at frame-end still counted as locked
// PORTS
//   clk           in   1   system clock
//   rst           in   1   synchronous, active-high reset
//   i_lock_en     in   1   1 = re-phase on i_frame_end, 0 = free-run
//   i_frame_end   in   1   one-cycle pulse, PAL frame end (from upsampler)
//   o_pix_en      out  1   one-cycle strobe per HD pixel
//   o_hd_clk      out  1   pixel-rate square wave; falling edge once per pixel
//   o_hd_hsync    out  1   active-high horizontal sync
//   o_hd_vsync    out  1   active-high vertical sync
//   o_hd_de       out  1   active video
//   o_hd_x        out  11  horizontal position (0..H_TOTAL-1)
//   o_hd_y        out  10  vertical position (0..V_TOTAL-1)
//   o_locked      out  1   last frame-end landed within LOCK_TOL
// BEHAVIOUR
//   - Reset: all counters 0; all outputs 0. Reset mid-frame restarts at x=0,y=0 next cycle.
//   - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750).
//   - div counter 0..CLK_DIV-1, wraps; pix_en = (div==CLK_DIV-1). o_hd_clk = 1 while div < CLK_DIV/2.
//   - On pix_en: h wraps H_TOTAL-1 -> 0; on h wrap v increments, wraps V_TOTAL-1 -> 0.
//   - Line order: active [0,H_ACTIVE), FP, sync, BP. hsync = h in [H_ACTIVE+H_FP, +H_SYNC).
//   - vsync = v in [V_ACTIVE+V_FP, +V_SYNC), full lines. de = h<H_ACTIVE && v<V_ACTIVE.
//   - All sync/de/x/y outputs registered, 1 clk latency from counters, mutually aligned.
//   - Lock: i_frame_end with i_lock_en=1 sets rephase_pend. At next line wrap v loads LOCK_LINE
//     (not v+1) and pend clears. Pulse in the same cycle as a line wrap applies at that wrap.
//     Further pulses while pending are absorbed (single re-phase). i_lock_en=0: pulse ignored,
//     pending cleared.
//   - o_locked updates on every accepted pulse: 1 if circular distance(v, LOCK_LINE) <= LOCK_TOL,
//     else 0. Cleared when i_lock_en deasserts or on rst.
//   - Widths: x 11b, y 10b; comparisons unsigned; distance computed modulo V_TOTAL.
// STRUCTURE
//   - Package hd_timing_pkg: 720p constants, H_TOTAL/V_TOTAL, x/y width localparams.
//   - Sub-module pix_clk_div: div counter, o_pix_en, o_hd_clk.
//   - Top: h/v counters, sync/de decode, lock FSM (IDLE, PEND).
// TESTING
//   - Reset then free-run, CLK_DIV=2 -> pix_en every 2 clks; hsync high x 1390..1429; 1650 px/line.
//   - Full frame -> vsync high for lines 725..729; de count = 921600 pixels/frame.
//   - i_lock_en=1, pulse at y=300 -> next line y=0; o_locked=0; next pulse at y=0 -> o_locked=1.
//   - Pulse coincident with line wrap at y=748 -> that wrap loads y=0; distance 2 -> o_locked=1.
//   - Two pulses in one line -> exactly one re-phase; i_lock_en=0 pulse -> y unchanged, o_locked=0.
//   - rst asserted mid-line (x=700,y=400) -> next cycle outputs 0; restart at x=0,y=0.

Source files
------------

// File: rtl/hd_timing_pkg.sv
// 720p raster constants, counter widths and the circular line-distance helper
// shared by the HD timing generator.
package hd_timing_pkg;

    localparam int CLK_DIV_DEF   = 2;
    localparam int H_ACTIVE_DEF  = 1280;
    localparam int H_FP_DEF      = 110;
    localparam int H_SYNC_DEF    = 40;
    localparam int H_BP_DEF      = 220;
    localparam int V_ACTIVE_DEF  = 720;
    localparam int V_FP_DEF      = 5;
    localparam int V_SYNC_DEF    = 5;
    localparam int V_BP_DEF      = 20;
    localparam int LOCK_LINE_DEF = 0;
    localparam int LOCK_TOL_DEF  = 2;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    // Lock FSM encoding; the lock FSM only ever waits for one line wrap.
    localparam logic [0:0] LOCK_IDLE = 1'b0;
    localparam logic [0:0] LOCK_PEND = 1'b1;

    // Shortest distance between two line numbers on a ring of 'total' lines.
    function automatic logic [Y_W-1:0] circ_dist(input logic [Y_W-1:0] a,
                                                 input logic [Y_W-1:0] b,
                                                 input logic [Y_W-1:0] total);
        logic [Y_W-1:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return (d <= (total - d)) ? d : (total - d);
    endfunction

endpackage

// File: rtl/pix_clk_div.sv
// Pixel-rate divider: produces the internal pixel tick plus the registered
// pixel strobe and pixel-rate square wave.
module pix_clk_div
    import hd_timing_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o,
    output logic pix_en_o,
    output logic hd_clk_o
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q;
    logic             hd_clk_q;

    // Tick is the last divider phase; counters in the top advance on it.
    assign tick_o = (div_q == DIV_LAST);

    // Next divider phase, wrapping after the last phase.
    always_comb begin
        div_d = tick_o ? '0 : (div_q + DIV_W'(1));
    end

    // Divider state and registered strobe/clock so they align with the
    // registered sync/position outputs of the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            hd_clk_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= tick_o;
            hd_clk_q <= (div_q < DIV_HALF);
        end
    end

    assign pix_en_o = pix_en_q;
    assign hd_clk_o = hd_clk_q;

endmodule

// File: rtl/hd_timing_gen.sv
// HD raster timing generator: h/v counters, sync/de decode and an optional
// vertical re-phase that keeps HD frames locked to the PAL frame-end pulse.
// Handshake: i_frame_end is a one-cycle strobe with no back-pressure; every
// cycle it is high counts as one pulse.
module hd_timing_gen
    import hd_timing_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter int LOCK_LINE = LOCK_LINE_DEF,
    parameter int LOCK_TOL  = LOCK_TOL_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_lock_en,
    input  logic           i_frame_end,
    output logic           o_pix_en,
    output logic           o_hd_clk,
    output logic           o_hd_hsync,
    output logic           o_hd_vsync,
    output logic           o_hd_de,
    output logic [X_W-1:0] o_hd_x,
    output logic [Y_W-1:0] o_hd_y,
    output logic           o_locked,
    output logic           o_dbg_lock_state
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] V_TOT    = Y_W'(V_TOTAL);
    localparam logic [Y_W-1:0] V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [Y_W-1:0] LOCK_V   = Y_W'(LOCK_LINE);
    localparam logic [Y_W-1:0] TOL_V    = Y_W'(LOCK_TOL);

    logic           tick;
    logic           line_wrap;
    logic           rephase;
    logic [X_W-1:0] h_q, h_d;
    logic [Y_W-1:0] v_q, v_d;
    logic [0:0]     state_q, state_d;
    logic           locked_q, locked_d;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic           hs_q, vs_q, de_q;

    pix_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_div (
        .clk      (clk),
        .rst      (rst),
        .tick_o   (tick),
        .pix_en_o (o_pix_en),
        .hd_clk_o (o_hd_clk)
    );

    assign line_wrap = tick && (h_q == H_LAST);
    // A pulse arriving on the wrap cycle itself is applied at that wrap.
    assign rephase   = line_wrap && i_lock_en &&
                       ((state_q == LOCK_PEND) || i_frame_end);

    // Counter next-state: h per pixel, v per line, v reloaded on re-phase.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (tick) begin
            h_d = line_wrap ? '0 : (h_q + X_W'(1));
        end
        if (line_wrap) begin
            if (rephase) begin
                v_d = LOCK_V;
            end else begin
                v_d = (v_q == V_LAST) ? '0 : (v_q + Y_W'(1));
            end
        end
    end

    // Lock FSM and lock status: a pending re-phase is consumed by the next
    // line wrap; extra pulses while pending only refresh the lock status.
    always_comb begin
        state_d  = state_q;
        locked_d = locked_q;
        if (!i_lock_en) begin
            state_d  = LOCK_IDLE;
            locked_d = 1'b0;
        end else begin
            if (line_wrap) begin
                state_d = LOCK_IDLE;
            end else if (i_frame_end) begin
                state_d = LOCK_PEND;
            end
            if (i_frame_end) begin
                locked_d = (circ_dist(v_q, LOCK_V, V_TOT) <= TOL_V);
            end
        end
    end

    // Counter, FSM and registered decode of the current counter values.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q      <= '0;
            v_q      <= '0;
            state_q  <= LOCK_IDLE;
            locked_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            de_q     <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            state_q  <= state_d;
            locked_q <= locked_d;
            x_q      <= h_q;
            y_q      <= v_q;
            hs_q     <= (h_q >= HS_START) && (h_q < HS_END);
            vs_q     <= (v_q >= VS_START) && (v_q < VS_END);
            de_q     <= (h_q < H_ACT) && (v_q < V_ACT);
        end
    end

    assign o_hd_x           = x_q;
    assign o_hd_y           = y_q;
    assign o_hd_hsync       = hs_q;
    assign o_hd_vsync       = vs_q;
    assign o_hd_de          = de_q;
    assign o_locked         = locked_q;
    assign o_dbg_lock_state = state_q[0];

endmodule
